shared_mul_gf4_selftest: RTL and testbench
==========================================

# shared_mul_gf4_selftest

Self-test controller and response checker for the 2-share (parameterizable) DOM GF(2^4) multiplier `shared_mul_gf4`. It sweeps all 256 operand pairs twice through an external DUT instance and records the recombined results. The first pass uses all-zero masks and fills a 256-entry golden table. The second pass uses LFSR-generated masks and fresh randomness, and compares each recombined output against the table. It sits next to the S-box datapath as the receiving and checking end of the multiplier's shared interface, and is usable on-chip as BIST.

## Interface
Parameters:
- `SHARES`, 2: number of shares, ≥2.
- `LATENCY`, 1: DUT input-to-output latency in cycles, ≥1. It must match the DUT's `PIPELINED` setting.
- `SEED`, 32'hACE1_2357: LFSR reset value, nonzero.

Ports:
- `ClkxCI` in 1: clock.
- `RstxRI` in 1: reset, synchronous, active-high.
- `StartxSI` in 1: one-cycle start pulse. It is ignored unless the FSM is in IDLE or DONE.
- `_XxDO` out 4*SHARES: X shares to DUT. Share i occupies bits [4i+3:4i].
- `_YxDO` out 4*SHARES: Y shares to DUT, same packing as X.
- `_ZxDO` out 2*SHARES*(SHARES-1): fresh randomness to DUT.
- `_QxDI` in 4*SHARES: DUT output shares.
- `BusyxSO` out 1: high from the first cycle of REF through the last cycle of DRAIN2.
- `DonexSO` out 1: high in DONE.
- `PassxSO` out 1: valid when DonexSO is high; 1 if the error count is 0.
- `ErrCntxDO` out 9: number of mismatches in pass 2, range 0..256.
- `FirstErrxDO` out 8: {x,y} of the first mismatch. Holds 8'h00 when there is none.

## Operation
- Packed-share recombination: value = XOR of all SHARES 4-bit slices.
- Issue counter `IdxxD` is 8 bits: x = Idx[7:4], y = Idx[3:0]. It advances by 1 each cycle in REF/CHK and wraps 255→0 at the pass end.
- Masking in REF:
  - share0 = x (or y); shares 1..SHARES-1 = 0.
  - `_ZxDO` = 0.
- Masking in CHK:
  - Each cycle a 32-bit Galois LFSR (poly x^32+x^22+x^2+x+1) steps once.
  - Masks m1..m(SHARES-1) for X and for Y, plus Z, are taken from successive LFSR bits. When more bits are needed than one LFSR word holds, the LFSR steps repeatedly within the cycle (unrolled combinationally).
  - share0 = x ^ m1 ^ … ^ m(SHARES-1); share i = mi. Y is handled the same way with independent masks.
- Tag pipeline: a LATENCY-deep shift register carries {valid, Idx} alongside the DUT.
- Capture: when the tag output is valid, the recombined Q is
  - in REF/DRAIN1, written to `Gold[Idx]`;
  - in CHK/DRAIN2, compared with `Gold[Idx]`. On mismatch, ErrCnt increments (saturating at 256). FirstErr is loaded only if ErrCnt was 0.
- FSM:
  - IDLE → REF on Start. Start clears ErrCnt and FirstErr and resets Idx to 0. The LFSR is not reset and keeps running between runs.
  - REF → DRAIN1 after issuing Idx=255.
  - DRAIN1 → CHK after LATENCY cycles with no issue. The tag pipe is empty at this point.
  - CHK → DRAIN2 after Idx=255.
  - DRAIN2 → DONE after LATENCY cycles.
  - DONE → REF on Start.
- Outputs are driven to all zeros whenever no issue occurs (IDLE, DRAIN1, DRAIN2, DONE).

## Timing
- Reset (synchronous, sampled on rising edge):
  - FSM=IDLE, Idx=0, tag pipe cleared, LFSR=SEED, ErrCnt=0, FirstErr=0.
  - All `_x` outputs = 0; BusyxSO=0, DonexSO=0, PassxSO=0.
  - Gold contents are undefined; they are always rewritten by REF before use.
- Reset mid-run aborts immediately. The next cycle is IDLE with all outputs at reset values.
- Start sampled high in IDLE: the first REF issue (Idx=0) appears on the outputs the following cycle.
- Run length from the first REF issue to DonexSO rising: 256 + LATENCY + 256 + LATENCY cycles.
- The result for an issue at cycle t is sampled from `_QxDI` at cycle t+LATENCY.
- Start asserted while busy is ignored. Start asserted in the same cycle as reset is ignored, because reset wins.

## Test plan
- Correct DUT (SHARES=2, LATENCY=1), Start pulse → DonexSO after 514 cycles; PassxSO=1, ErrCnt=0, FirstErr=8'h00.
- DUT model that flips Q share1 bit0 only when the inputs carry nonzero masks → ErrCnt = 256, FirstErr = 8'h00 with the Done timing above. (The flip is absent during REF because REF masks are zero.)
- DUT model that corrupts only when the recombined product of {x=3, y=5} is produced with any share1 ≠ 0 → ErrCnt=1, FirstErr=8'h35, PassxSO=0.
- Probe `_XxDO` during CHK: the XOR of the shares always equals Idx[7:4], and share1 is not constant over 256 cycles. During REF, share1 is always 0 and `_ZxDO`=0.
- Assert RstxRI for one cycle at cycle 300 of a run → the next cycle shows BusyxSO=0 and all outputs 0. A new Start then completes with Pass=1.
- SHARES=3, LATENCY=2 with a correct DUT → Done after 516 cycles with PassxSO=1. Start pulses issued during the run have no effect.

Source files
------------

// File: rtl/shared_mul_gf4_selftest_if.sv
// Shared-operand bus between the GF(2^4) multiplier self-test and the multiplier under test.
// Share i of X, Y and Q occupies bits [4i+3:4i]; Z carries the fresh randomness.
interface shared_mul_gf4_selftest_if #(
    parameter int SHARES = 2
);
    logic [4*SHARES-1:0]            _XxDO;
    logic [4*SHARES-1:0]            _YxDO;
    logic [2*SHARES*(SHARES-1)-1:0] _ZxDO;
    logic [4*SHARES-1:0]            _QxDI;

    modport master (
        output _XxDO,
        output _YxDO,
        output _ZxDO,
        input  _QxDI
    );

    modport slave (
        input  _XxDO,
        input  _YxDO,
        input  _ZxDO,
        output _QxDI
    );
endinterface

// File: rtl/shared_mul_gf4_selftest.sv
// Self-test sequencer and response checker for the shared GF(2^4) multiplier: an unmasked
// reference sweep fills a golden table, then a masked sweep is compared against it.
//
// state  | meaning
// IDLE   | waiting for Start after reset
// REF    | issuing all 256 {x,y} pairs with zero masks, results go to the golden table
// DRAIN1 | LATENCY cycles with no issue so the last reference result lands
// CHK    | issuing all 256 pairs with LFSR masks, results compared to the golden table
// DRAIN2 | LATENCY cycles with no issue so the last checked result lands
// DONE   | verdict valid, Start begins a new run
module shared_mul_gf4_selftest #(
    parameter int          SHARES  = 2,
    parameter int          LATENCY = 1,
    parameter logic [31:0] SEED    = 32'hACE1_2357
) (
    input  logic                             ClkxCI,
    input  logic                             RstxRI,
    input  logic                             StartxSI,
    shared_mul_gf4_selftest_if.master        mulBus,
    output logic                             BusyxSO,
    output logic                             DonexSO,
    output logic                             PassxSO,
    output logic [8:0]                       ErrCntxDO,
    output logic [7:0]                       FirstErrxDO
);

    localparam int          ZW     = 2*SHARES*(SHARES-1);
    localparam int          MASKW  = 8*(SHARES-1) + ZW;
    localparam int          NWORDS = (MASKW + 31) / 32;
    localparam int          DCW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    if (SHARES < 2) begin : gSharesChk
        $error("SHARES must be at least 2");
    end
    if (LATENCY < 1) begin : gLatencyChk
        $error("LATENCY must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REF    = 3'd1,
        DRAIN1 = 3'd2,
        CHK    = 3'd3,
        DRAIN2 = 3'd4,
        DONE   = 3'd5
    } stateT;

    stateT              statexDP, statexDN;
    logic [7:0]         idxxDP, idxxDN;
    logic [DCW-1:0]     drainCntxDP, drainCntxDN;
    logic               startAccept;
    logic [31:0]        lfsrxDP, lfsrNext, lfsrWalk;
    logic [32*NWORDS-1:0] poolFull;
    logic [MASKW-1:0]   maskPool;
    logic [4*SHARES-1:0] xShares, yShares;
    logic [ZW-1:0]      zBits;
    logic [3:0]         xAcc, yAcc;
    logic [3:0]         qRecomb;
    logic               tagVldxDP [LATENCY];
    logic [7:0]         tagIdxxDP [LATENCY];
    logic               capVld;
    logic [7:0]         capIdx;
    logic               goldWr, mismatch;
    logic [3:0]         goldxDP [256];
    logic [8:0]         errCntxDP;
    logic [7:0]         firstErrxDP;
    logic               issue;

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            statexDP    <= IDLE;
            idxxDP      <= 8'h00;
            drainCntxDP <= '0;
        end else begin
            statexDP    <= statexDN;
            idxxDP      <= idxxDN;
            drainCntxDP <= drainCntxDN;
        end
    end

    always_comb begin
        statexDN    = statexDP;
        idxxDN      = idxxDP;
        drainCntxDN = drainCntxDP;
        startAccept = 1'b0;
        case (statexDP)
            IDLE, DONE: begin
                if (StartxSI) begin
                    statexDN    = REF;
                    idxxDN      = 8'h00;
                    startAccept = 1'b1;
                end
            end
            REF: begin
                idxxDN = idxxDP + 8'd1;
                if (idxxDP == 8'hFF) begin
                    statexDN    = DRAIN1;
                    drainCntxDN = DCW'(LATENCY-1);
                end
            end
            DRAIN1: begin
                if (drainCntxDP == '0) statexDN = CHK;
                else                   drainCntxDN = drainCntxDP - 1'b1;
            end
            CHK: begin
                idxxDN = idxxDP + 8'd1;
                if (idxxDP == 8'hFF) begin
                    statexDN    = DRAIN2;
                    drainCntxDN = DCW'(LATENCY-1);
                end
            end
            DRAIN2: begin
                if (drainCntxDP == '0) statexDN = DONE;
                else                   drainCntxDN = drainCntxDP - 1'b1;
            end
            default: statexDN = IDLE;
        endcase
    end

    assign issue = (statexDP == REF) || (statexDP == CHK);

    // The LFSR free-runs in every state, so successive runs see different masks.
    always_comb begin
        lfsrWalk = lfsrxDP;
        poolFull = '0;
        for (int i = 0; i < NWORDS; i++) begin
            poolFull[32*i +: 32] = lfsrWalk;
            lfsrWalk = lfsrStep(lfsrWalk);
        end
        lfsrNext = lfsrWalk;
        maskPool = MASKW'(poolFull);
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) lfsrxDP <= SEED;
        else        lfsrxDP <= lfsrNext;
    end

    always_comb begin
        xShares = '0;
        yShares = '0;
        zBits   = '0;
        xAcc    = idxxDP[7:4];
        yAcc    = idxxDP[3:0];
        if (statexDP == REF) begin
            xShares[3:0] = idxxDP[7:4];
            yShares[3:0] = idxxDP[3:0];
        end else if (statexDP == CHK) begin
            for (int i = 1; i < SHARES; i++) begin
                xShares[4*i +: 4] = maskPool[4*(i-1) +: 4];
                yShares[4*i +: 4] = maskPool[4*(SHARES-1) + 4*(i-1) +: 4];
                xAcc = xAcc ^ maskPool[4*(i-1) +: 4];
                yAcc = yAcc ^ maskPool[4*(SHARES-1) + 4*(i-1) +: 4];
            end
            xShares[3:0] = xAcc;
            yShares[3:0] = yAcc;
            zBits        = maskPool[8*(SHARES-1) +: ZW];
        end
    end

    assign mulBus._XxDO = xShares;
    assign mulBus._YxDO = yShares;
    assign mulBus._ZxDO = zBits;

    // Tag pipe mirrors the multiplier latency so each result knows which pair produced it.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            for (int i = 0; i < LATENCY; i++) begin
                tagVldxDP[i] <= 1'b0;
                tagIdxxDP[i] <= 8'h00;
            end
        end else begin
            tagVldxDP[0] <= issue;
            tagIdxxDP[0] <= idxxDP;
            for (int i = 1; i < LATENCY; i++) begin
                tagVldxDP[i] <= tagVldxDP[i-1];
                tagIdxxDP[i] <= tagIdxxDP[i-1];
            end
        end
    end

    assign capVld = tagVldxDP[LATENCY-1];
    assign capIdx = tagIdxxDP[LATENCY-1];

    always_comb begin
        qRecomb = 4'h0;
        for (int i = 0; i < SHARES; i++) qRecomb = qRecomb ^ mulBus._QxDI[4*i +: 4];
    end

    assign goldWr   = capVld && ((statexDP == REF) || (statexDP == DRAIN1));
    assign mismatch = capVld && ((statexDP == CHK) || (statexDP == DRAIN2))
                      && (qRecomb != goldxDP[capIdx]);

    always_ff @(posedge ClkxCI) begin
        if (goldWr) goldxDP[capIdx] <= qRecomb;
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            errCntxDP   <= 9'd0;
            firstErrxDP <= 8'h00;
        end else if (startAccept) begin
            errCntxDP   <= 9'd0;
            firstErrxDP <= 8'h00;
        end else if (mismatch) begin
            if (errCntxDP != 9'd256) errCntxDP <= errCntxDP + 9'd1;
            if (errCntxDP == 9'd0)   firstErrxDP <= capIdx;
        end
    end

    assign BusyxSO     = (statexDP == REF) || (statexDP == DRAIN1)
                         || (statexDP == CHK) || (statexDP == DRAIN2);
    assign DonexSO     = (statexDP == DONE);
    assign PassxSO     = (statexDP == DONE) && (errCntxDP == 9'd0);
    assign ErrCntxDO   = errCntxDP;
    assign FirstErrxDO = firstErrxDP;

endmodule

// File: tb/tb_shared_mul_gf4_selftest.sv
// Bench for the multiplier self-test: behavioural shared multipliers with injectable faults
// drive two instances (2 shares/latency 1 and 3 shares/latency 2).
module tb_shared_mul_gf4_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst2, start2, busy2, done2, pass2;
    logic [8:0] err2;
    logic [7:0] first2;
    logic       rst3, start3, busy3, done3, pass3;
    logic [8:0] err3;
    logic [7:0] first3;

    shared_mul_gf4_selftest_if #(.SHARES(2)) bus2 ();
    shared_mul_gf4_selftest_if #(.SHARES(3)) bus3 ();

    shared_mul_gf4_selftest #(.SHARES(2), .LATENCY(1)) dut2 (
        .ClkxCI(clk), .RstxRI(rst2), .StartxSI(start2), .mulBus(bus2),
        .BusyxSO(busy2), .DonexSO(done2), .PassxSO(pass2),
        .ErrCntxDO(err2), .FirstErrxDO(first2)
    );

    shared_mul_gf4_selftest #(.SHARES(3), .LATENCY(2)) dut3 (
        .ClkxCI(clk), .RstxRI(rst3), .StartxSI(start3), .mulBus(bus3),
        .BusyxSO(busy3), .DonexSO(done3), .PassxSO(pass3),
        .ErrCntxDO(err3), .FirstErrxDO(first3)
    );

    // Fault model configuration and log of every corrupted result ({x,y} of the pair).
    int         faultMode = 0;
    logic [3:0] faultX = 4'h0;
    logic [3:0] faultY = 4'h0;
    logic [7:0] injLog[$];

    function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc = 4'h0;
        logic [3:0] aa  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    function automatic logic fault2(input logic [7:0] xs, input logic [7:0] ys, input logic [3:0] zs);
        logic [3:0] xr = xs[3:0] ^ xs[7:4];
        logic [3:0] yr = ys[3:0] ^ ys[7:4];
        if (faultMode == 1) return (xs[7:4] != 4'h0) || (ys[7:4] != 4'h0) || (zs != 4'h0);
        if (faultMode == 2) return (xr == faultX) && (yr == faultY)
                                   && ((xs[7:4] != 4'h0) || (ys[7:4] != 4'h0));
        return 1'b0;
    endfunction

    function automatic logic [7:0] shareOut2(input logic [7:0] xs, input logic [7:0] ys,
                                             input logic [3:0] r, input logic flip);
        logic [3:0] p = gfMul(xs[3:0] ^ xs[7:4], ys[3:0] ^ ys[7:4]);
        return {r[3:1], r[0] ^ flip, p ^ r};
    endfunction

    function automatic logic [11:0] shareOut3(input logic [11:0] xs, input logic [11:0] ys,
                                              input logic [7:0] r);
        logic [3:0] p = gfMul(xs[3:0] ^ xs[7:4] ^ xs[11:8], ys[3:0] ^ ys[7:4] ^ ys[11:8]);
        return {r[7:4], r[3:0], p ^ r[7:4] ^ r[3:0]};
    endfunction

    logic [7:0]  q2 = 8'h00;
    logic [11:0] q3a = 12'h000;
    logic [11:0] q3 = 12'h000;
    assign bus2._QxDI = q2;
    assign bus3._QxDI = q3;

    always @(posedge clk) begin
        q2 <= shareOut2(bus2._XxDO, bus2._YxDO, 4'($urandom),
                        fault2(bus2._XxDO, bus2._YxDO, bus2._ZxDO));
        if (fault2(bus2._XxDO, bus2._YxDO, bus2._ZxDO))
            injLog.push_back({bus2._XxDO[3:0] ^ bus2._XxDO[7:4], bus2._YxDO[3:0] ^ bus2._YxDO[7:4]});
    end

    always @(posedge clk) begin
        q3a <= shareOut3(bus3._XxDO, bus3._YxDO, 8'($urandom));
        q3  <= q3a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         mode;
        logic [3:0] fx;
        logic [3:0] fy;
        int         minInj;
        int         maxInj;
        logic       randStart;
    } vecT;

    // One full run on the 2-share instance; pair index is derived from cycles since first issue.
    task automatic run2(input vecT v, input string tag);
        int k, refBad, chkBad, drainBad, nInj, expErr;
        logic [7:0] idx, xs, ys, expFirst;
        logic [3:0] zs, x1First, y1First;
        logic x1Var, y1Var;
        refBad = 0; chkBad = 0; drainBad = 0;
        x1First = 4'h0; y1First = 4'h0; x1Var = 1'b0; y1Var = 1'b0;
        faultMode = v.mode; faultX = v.fx; faultY = v.fy;
        injLog.delete();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        check({tag, "_start_to_busy"}, 32'(busy2), 32'd1);
        k = 0;
        while (!done2 && k < 700) begin
            xs = bus2._XxDO; ys = bus2._YxDO; zs = bus2._ZxDO;
            if (k < 256) begin
                idx = 8'(k);
                if (xs !== {4'h0, idx[7:4]} || ys !== {4'h0, idx[3:0]} || zs !== 4'h0) refBad++;
            end else if (k >= 257 && k < 513) begin
                idx = 8'(k - 257);
                if ((xs[3:0] ^ xs[7:4]) !== idx[7:4] || (ys[3:0] ^ ys[7:4]) !== idx[3:0]) chkBad++;
                if (k == 257) begin
                    x1First = xs[7:4]; y1First = ys[7:4];
                end else begin
                    if (xs[7:4] !== x1First) x1Var = 1'b1;
                    if (ys[7:4] !== y1First) y1Var = 1'b1;
                end
            end else if (xs !== 8'h00 || ys !== 8'h00 || zs !== 4'h0) begin
                drainBad++;
            end
            if (v.randStart) start2 = (k > 3 && k < 500 && $urandom_range(0, 31) == 0);
            @(negedge clk);
            k++;
        end
        start2 = 1'b0;
        if (bus2._XxDO !== 8'h00 || bus2._YxDO !== 8'h00 || bus2._ZxDO !== 4'h0) drainBad++;
        check({tag, "_run_len"}, 32'(k), 32'd514);
        check({tag, "_busy_at_done"}, 32'(busy2), 32'd0);
        check({tag, "_ref_probe_bad"}, 32'(refBad), 32'd0);
        check({tag, "_chk_xor_bad"}, 32'(chkBad), 32'd0);
        check({tag, "_idle_outputs_bad"}, 32'(drainBad), 32'd0);
        check({tag, "_x_share1_varies"}, 32'(x1Var), 32'd1);
        check({tag, "_y_share1_varies"}, 32'(y1Var), 32'd1);
        nInj     = injLog.size();
        expErr   = (nInj > 256) ? 256 : nInj;
        expFirst = (nInj > 0) ? injLog[0] : 8'h00;
        check({tag, "_inj_in_range"}, 32'(nInj >= v.minInj && nInj <= v.maxInj), 32'd1);
        check({tag, "_err_cnt"}, 32'(err2), 32'(expErr));
        check({tag, "_first_err"}, 32'(first2), 32'(expFirst));
        check({tag, "_pass"}, 32'(pass2), 32'(nInj == 0));
    endtask

    task automatic abortRun2();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_busy_before_reset", 32'(busy2), 32'd1);
        rst2 = 1'b1;
        @(negedge clk); rst2 = 1'b0;
        check("abort_busy", 32'(busy2), 32'd0);
        check("abort_outputs", {bus2._XxDO, bus2._YxDO, bus2._ZxDO, done2, pass2, err2}, 32'd0);
        check("abort_first_err", 32'(first2), 32'd0);
    endtask

    task automatic run3();
        int k;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        check("s3_start_to_busy", 32'(busy3), 32'd1);
        k = 0;
        while (!done3 && k < 700) begin
            start3 = (k > 3 && k < 500 && $urandom_range(0, 15) == 0);
            @(negedge clk);
            k++;
        end
        start3 = 1'b0;
        check("s3_run_len", 32'(k), 32'd516);
        check("s3_pass", 32'(pass3), 32'd1);
        check("s3_err_cnt", 32'(err3), 32'd0);
        check("s3_first_err", 32'(first3), 32'd0);
        repeat (3) @(negedge clk);
        check("s3_done_holds", 32'(done3), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecT vecs[4];
        vecT rv;
        vecs[0] = '{mode: 0, fx: 4'h0, fy: 4'h0, minInj: 0,   maxInj: 0,   randStart: 1'b1};
        vecs[1] = '{mode: 1, fx: 4'h0, fy: 4'h0, minInj: 240, maxInj: 256, randStart: 1'b0};
        vecs[2] = '{mode: 2, fx: 4'h3, fy: 4'h5, minInj: 0,   maxInj: 1,   randStart: 1'b0};
        vecs[3] = '{mode: 0, fx: 4'h0, fy: 4'h0, minInj: 0,   maxInj: 0,   randStart: 1'b0};

        rst2 = 1'b1; rst3 = 1'b1; start2 = 1'b0; start3 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy2), 32'd0);
        check("reset_outputs", {bus2._XxDO, bus2._YxDO, bus2._ZxDO, done2, pass2, err2}, 32'd0);
        check("reset_first_err", 32'(first2), 32'd0);

        rst2 = 1'b1; start2 = 1'b1;
        @(negedge clk); rst2 = 1'b0; start2 = 1'b0;
        @(negedge clk);
        check("start_during_reset_ignored", 32'(busy2), 32'd0);

        for (int i = 0; i < 4; i++) run2(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 3; i++) begin
            rv = '{mode: 2, fx: 4'($urandom_range(0, 15)), fy: 4'($urandom_range(0, 15)),
                   minInj: 0, maxInj: 1, randStart: 1'b1};
            run2(rv, $sformatf("rnd%0d", i));
        end

        abortRun2();
        run2(vecs[3], "after_abort");

        run3();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
